// File: rtl/icache_refill_unit_pkg.sv
// Shared fetch-side definitions for the I-cache refill path: widths, derived
// block geometry and the refill FSM state encoding.
package icache_refill_unit_pkg;

   localparam int SIZE_PC     = 32;
   localparam int CACHE_WIDTH = 256;
   localparam int MEM_WIDTH   = 64;
   localparam int BEATS       = CACHE_WIDTH / MEM_WIDTH;
   localparam int BLK_OFF     = $clog2(CACHE_WIDTH / 8);
   localparam int CNT_W       = $clog2(BEATS);

   // Clears the byte-offset bits so any PC inside a block maps to its base.
   localparam logic [SIZE_PC-1:0] BLK_MASK = {{(SIZE_PC-BLK_OFF){1'b1}}, {BLK_OFF{1'b0}}};

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      FILL  = 3'd2,
      WRITE = 3'd3,
      HOLD  = 3'd4
   } refill_state_e;

endpackage

// File: rtl/icache_refill_unit_if.sv
// Miss, I-cache write-back and memory burst signals of the refill unit.
// master = refill unit, slave = fetch stage / memory side.
interface icache_refill_unit_if;
   import icache_refill_unit_pkg::*;

   logic                   miss_i;
   logic [SIZE_PC-1:0]     missAddr_i;
   logic                   wrEnable_o;
   logic [SIZE_PC-1:0]     wrAddr_o;
   logic [CACHE_WIDTH-1:0] instBlock_o;
   logic                   memReq_o;
   logic [SIZE_PC-1:0]     memAddr_o;
   logic                   memGnt_i;
   logic                   memValid_i;
   logic [MEM_WIDTH-1:0]   memData_i;

   modport master (
      input  miss_i, missAddr_i, memGnt_i, memValid_i, memData_i,
      output wrEnable_o, wrAddr_o, instBlock_o, memReq_o, memAddr_o
   );

   modport slave (
      output miss_i, missAddr_i, memGnt_i, memValid_i, memData_i,
      input  wrEnable_o, wrAddr_o, instBlock_o, memReq_o, memAddr_o
   );

endinterface

// File: rtl/icache_refill_unit_refill_beat_buffer.sv
// Assembly register for one cache block; exposes the block as it will look
// once the current beat lands, plus a flag for the final beat.
module refill_beat_buffer
   import icache_refill_unit_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   i_wr,
   input  logic [CNT_W-1:0]       i_slot,
   input  logic [MEM_WIDTH-1:0]   i_data,
   output logic [CACHE_WIDTH-1:0] o_block_next,
   output logic                   o_done
);

   logic [BEATS-1:0][MEM_WIDTH-1:0] r_beats;
   logic [BEATS-1:0][MEM_WIDTH-1:0] w_next;

   // NOTE: the buffer is cleared on reset because its contents become a visible
   // output; a pure datapath store would normally be left unreset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_beats <= '0;
      end else if (i_wr) begin
         r_beats[i_slot] <= i_data;
      end
   end

   // NOTE: w_next gets a full default before the slice update, so no latch forms.
   always_comb begin
      w_next         = r_beats;
      w_next[i_slot] = i_data;
   end

   assign o_block_next = w_next;
   assign o_done       = i_wr && (i_slot == CNT_W'(BEATS - 1));

endmodule

// File: rtl/icache_refill_unit.sv
// L1 I-cache refill engine: one burst read per miss, beats assembled into a
// block, then a single-cycle write back into the cache.
module icache_refill_unit
   import icache_refill_unit_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   icache_refill_unit_if.master bus,
   output logic                 busy_o,
   output logic [31:0]          refillCount_o
);

   refill_state_e          r_state;
   logic [SIZE_PC-1:0]     r_blk_addr;
   logic [CNT_W-1:0]       r_cnt;
   logic                   r_mem_req;
   logic                   r_wr_en;
   logic [SIZE_PC-1:0]     r_wr_addr;
   logic [CACHE_WIDTH-1:0] r_inst_block;
   logic [31:0]            r_refill_count;

   logic                   w_beat_wr;
   logic                   w_done;
   logic [CACHE_WIDTH-1:0] w_block_next;

   assign w_beat_wr = (r_state == FILL) && bus.memValid_i;

   refill_beat_buffer u_buf (
      .clk          (clk),
      .reset        (reset),
      .i_wr         (w_beat_wr),
      .i_slot       (r_cnt),
      .i_data       (bus.memData_i),
      .o_block_next (w_block_next),
      .o_done       (w_done)
   );

   // NOTE: all state updates use <= so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state        <= IDLE;
         r_blk_addr     <= '0;
         r_cnt          <= '0;
         r_mem_req      <= 1'b0;
         r_wr_en        <= 1'b0;
         r_wr_addr      <= '0;
         r_inst_block   <= '0;
         r_refill_count <= '0;
      end else begin
         r_wr_en <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.miss_i) begin
                  r_blk_addr <= bus.missAddr_i & BLK_MASK;
                  r_mem_req  <= 1'b1;
                  r_state    <= REQ;
               end
            end
            REQ: begin
               if (bus.memGnt_i) begin
                  r_mem_req <= 1'b0;
                  r_cnt     <= '0;
                  r_state   <= FILL;
               end
            end
            FILL: begin
               if (w_beat_wr) begin
                  r_cnt <= r_cnt + CNT_W'(1);
                  if (w_done) begin
                     // Output registers are loaded here so they are valid during WRITE.
                     r_wr_en      <= 1'b1;
                     r_wr_addr    <= r_blk_addr;
                     r_inst_block <= w_block_next;
                     r_state      <= WRITE;
                  end
               end
            end
            WRITE: begin
               if (r_refill_count != '1) begin
                  r_refill_count <= r_refill_count + 32'd1;
               end
               r_state <= HOLD;
            end
            HOLD:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.memReq_o    = r_mem_req;
   assign bus.memAddr_o   = r_blk_addr;
   assign bus.wrEnable_o  = r_wr_en;
   assign bus.wrAddr_o    = r_wr_addr;
   assign bus.instBlock_o = r_inst_block;
   assign busy_o          = (r_state != IDLE);
   assign refillCount_o   = r_refill_count;

endmodule

// File: tb/tb_icache_refill_unit.sv
// Scoreboard bench for icache_refill_unit: expected requests and block writes
// are queued as stimulus is driven and compared when the DUT emits them.
module tb_icache_refill_unit;
   import icache_refill_unit_pkg::*;

   typedef struct {
      logic [SIZE_PC-1:0]     addr;
      logic [CACHE_WIDTH-1:0] blk;
   } wr_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        busy;
   logic [31:0] count;

   int n_tests = 0;
   int n_fail  = 0;

   wr_t                wq[$];
   logic [SIZE_PC-1:0] rq[$];

   icache_refill_unit_if bus ();

   icache_refill_unit dut (
      .clk           (clk),
      .reset         (reset),
      .bus           (bus),
      .busy_o        (busy),
      .refillCount_o (count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: accepted requests and block writes are popped in order.
   always @(negedge clk) begin
      if (reset && bus.memReq_o && bus.memGnt_i) begin
         if (rq.size() == 0) check("unexpected_req", 1'b1, 1'b0);
         else check("req_accept_addr", bus.memAddr_o, rq.pop_front());
      end
      if (reset && bus.wrEnable_o) begin
         if (wq.size() == 0) begin
            check("unexpected_write", 1'b1, 1'b0);
         end else begin
            wr_t e;
            e = wq.pop_front();
            check("wr_addr", bus.wrAddr_o, e.addr);
            check("wr_block", bus.instBlock_o, e.blk);
         end
      end
   end

   // One complete refill. Entered and left at posedge+1 with the DUT in IDLE.
   task automatic run_refill(input logic [31:0] addr, input int gnt_wait,
                             input logic [15:0] vpat, input int vlen,
                             input bit fixed_data, input bit redirect,
                             input logic [31:0] new_addr);
      logic [MEM_WIDTH-1:0]   beats [BEATS];
      logic [CACHE_WIDTH-1:0] blk;
      logic [SIZE_PC-1:0]     base;
      wr_t                    e;
      int                     k;
      int                     p;
      logic                   v;
      base = addr & ~32'h1F;
      for (int i = 0; i < BEATS; i++) begin
         beats[i] = fixed_data ? {8{8'((i + 1) * 8'h11)}} : {$urandom, $urandom};
         blk[i*MEM_WIDTH +: MEM_WIDTH] = beats[i];
      end
      e.addr = base;
      e.blk  = blk;
      wq.push_back(e);
      rq.push_back(base);

      bus.miss_i     = 1'b1;
      bus.missAddr_i = addr;
      tick();
      bus.miss_i = 1'b0;
      check("req_high", bus.memReq_o, 1'b1);
      check("req_addr", bus.memAddr_o, base);
      for (int i = 0; i < gnt_wait; i++) begin
         bus.memGnt_i = 1'b0;
         tick();
         check("req_stall_high", bus.memReq_o, 1'b1);
         check("req_stall_addr", bus.memAddr_o, base);
      end
      bus.memGnt_i = 1'b1;
      tick();
      bus.memGnt_i = 1'b0;
      check("req_dropped", bus.memReq_o, 1'b0);

      k = 0;
      p = 0;
      while (k < BEATS) begin
         v = (p < vlen) ? vpat[p] : 1'b1;
         p++;
         bus.memValid_i = v;
         bus.memData_i  = v ? beats[k] : {$urandom, $urandom};
         if (redirect && k == 1) begin
            bus.miss_i     = 1'b1;
            bus.missAddr_i = new_addr;
         end
         tick();
         if (v) k++;
         else check("no_early_write", bus.wrEnable_o, 1'b0);
      end
      bus.memValid_i = 1'b0;
      check("wr_pulse", bus.wrEnable_o, 1'b1);
      tick();
      check("wr_one_cycle", bus.wrEnable_o, 1'b0);
      check("busy_hold", busy, 1'b1);
      tick();
      check("idle_after_hold", busy, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.miss_i     = 1'b0;
      bus.missAddr_i = '0;
      bus.memGnt_i   = 1'b0;
      bus.memValid_i = 1'b0;
      bus.memData_i  = '0;
      reset = 1'b0;
      repeat (3) tick();
      check("rst_wr_en", bus.wrEnable_o, 1'b0);
      check("rst_wr_addr", bus.wrAddr_o, 32'h0);
      check("rst_block", bus.instBlock_o, 256'h0);
      check("rst_req", bus.memReq_o, 1'b0);
      check("rst_mem_addr", bus.memAddr_o, 32'h0);
      check("rst_busy", busy, 1'b0);
      check("rst_count", count, 32'h0);
      reset = 1'b1;
      tick();

      // Basic refill: immediate grant, back-to-back beats.
      run_refill(32'h0000_1234, 0, 16'h0, 0, 1'b1, 1'b0, 32'h0);
      check("basic_addr", bus.wrAddr_o, 32'h0000_1220);
      check("basic_lo", bus.instBlock_o[63:0], 64'h1111_1111_1111_1111);
      check("basic_hi", bus.instBlock_o[255:192], 64'h4444_4444_4444_4444);
      check("basic_count", count, 32'd1);
      repeat (3) tick();
      check("single_miss_no_rerun", busy, 1'b0);
      check("held_block_hi", bus.instBlock_o[255:192], 64'h4444_4444_4444_4444);

      // Grant stall of five cycles.
      run_refill(32'h0000_8F04, 5, 16'h0, 0, 1'b0, 1'b0, 32'h0);
      check("stall_count", count, 32'd2);

      // Gapped beats: valid pattern 1,0,0,1,1,0,1.
      run_refill(32'h0001_007C, 1, 16'b1011001, 7, 1'b0, 1'b0, 32'h0);
      check("gap_count", count, 32'd3);

      // Redirect mid-fill: stale block still written, new miss served after HOLD.
      run_refill(32'h0000_1234, 0, 16'h0, 0, 1'b0, 1'b1, 32'h0000_4000);
      check("redir_busy_idle", busy, 1'b0);
      run_refill(32'h0000_4000, 0, 16'h0, 0, 1'b0, 1'b0, 32'h0);
      check("redir_count", count, 32'd5);

      // Reset after two beats, then stray beats while IDLE.
      rq.push_back(32'h0000_2200);
      bus.miss_i     = 1'b1;
      bus.missAddr_i = 32'h0000_2210;
      tick();
      bus.miss_i   = 1'b0;
      bus.memGnt_i = 1'b1;
      tick();
      bus.memGnt_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bus.memValid_i = 1'b1;
         bus.memData_i  = {$urandom, $urandom};
         tick();
      end
      bus.memValid_i = 1'b0;
      reset = 1'b0;
      tick();
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         bus.memValid_i = 1'b1;
         bus.memData_i  = {$urandom, $urandom};
         tick();
      end
      bus.memValid_i = 1'b0;
      repeat (6) begin
         tick();
         check("rstfill_no_write", bus.wrEnable_o, 1'b0);
      end
      check("rstfill_busy", busy, 1'b0);
      check("rstfill_req", bus.memReq_o, 1'b0);
      check("rstfill_count", count, 32'd0);
      check("rstfill_block", bus.instBlock_o, 256'h0);

      // Saturation of the refill counter.
      force dut.r_refill_count = 32'hFFFF_FFFF;
      tick();
      release dut.r_refill_count;
      tick();
      check("sat_preload", count, 32'hFFFF_FFFF);
      run_refill(32'h0000_0040, 0, 16'h0, 0, 1'b0, 1'b0, 32'h0);
      check("sat_hold", count, 32'hFFFF_FFFF);

      repeat (3) tick();
      check("wq_drained", 32'(wq.size()), 32'd0);
      check("rq_drained", 32'(rq.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/icache_refill_unit.md
Name: icache_refill_unit

Overview:
- Lower-level responder for the L1 instruction-cache miss interface driven by the fetch stage.
- Accepts a miss request and issues one burst read to the memory port.
- Assembles the returned beats into a full cache block, then writes that block back into the L1 I-cache with a single-cycle write pulse.
- Sits between fetch stage 1 and the unified memory/L2 port.

Parameters:
- SIZE_PC, 32, width of PC and addresses.
- CACHE_WIDTH, 256, bits per cache block (4 instructions of 64 bits).
- MEM_WIDTH, 64, bits per memory data beat.
- BEATS, CACHE_WIDTH/MEM_WIDTH = 4, beats per block.
- BLK_OFF, log2(CACHE_WIDTH/8) = 5, byte-offset bits within a block.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- miss_i  in  1  I-cache miss flag from fetch stage 1.
- missAddr_i  in  SIZE_PC  miss PC (any byte within the block).
- wrEnable_o  out  1  one-cycle block write strobe to the I-cache.
- wrAddr_o  out  SIZE_PC  block-aligned write address.
- instBlock_o  out  CACHE_WIDTH  refilled block.
- memReq_o  out  1  burst read request.
- memAddr_o  out  SIZE_PC  block-aligned burst base address.
- memGnt_i  in  1  memory accepts the request when memReq_o & memGnt_i.
- memValid_i  in  1  data beat valid.
- memData_i  in  MEM_WIDTH  data beat.
- busy_o  out  1  refill in progress (any state other than IDLE).
- refillCount_o  out  32  completed refills, saturating at 2^32-1.

Behaviour:
- Reset (reset==0 at posedge clk):
  - state=IDLE; all outputs 0; beat counter 0; assembly buffer 0; refillCount_o 0.
  - Reset mid-refill abandons the refill immediately; no write is issued.
  - Memory beats arriving after reset are ignored while in IDLE.
- States: IDLE, REQ, FILL, WRITE, HOLD.
- IDLE:
  - If miss_i=1, latch blkAddr = missAddr_i with the low BLK_OFF bits cleared.
  - Go to REQ on the next cycle.
- REQ:
  - memReq_o=1 and memAddr_o=blkAddr, held stable until memGnt_i=1.
  - On grant, clear the beat counter and go to FILL.
  - No timeout.
- FILL:
  - Each cycle with memValid_i=1, write memData_i into buffer slice [cnt*MEM_WIDTH +: MEM_WIDTH], lowest address first, then increment cnt.
  - On the beat where cnt==BEATS-1, go to WRITE.
  - memValid_i=0 cycles stall the fill without losing state.
- WRITE:
  - Exactly one cycle: wrEnable_o=1, wrAddr_o=blkAddr, instBlock_o=buffer.
  - refillCount_o increments unless already saturated.
  - Go to HOLD.
- HOLD:
  - One dead cycle so the cache tag update is visible before miss_i is sampled again.
  - Prevents a duplicate refill of the same block. Go to IDLE.
- Latency:
  - miss_i sampled in IDLE (cycle 0) puts memReq_o high from cycle 1.
  - wrEnable_o pulses one cycle after the last beat.
  - With zero-wait grant and back-to-back beats: grant at cycle 1, beats at cycles 2–5, write at cycle 6, IDLE again at cycle 8.
- miss_i and missAddr_i are ignored outside IDLE.
- A fetch redirect that changes the miss address mid-refill does not abort the refill. The stale block is still written, which is harmless. The new miss is serviced after HOLD.
- miss_i held high through HOLD with an already-filled address causes a second refill. This is legal but wasteful. The bench checks that a single miss, cleared within one cycle of the write, causes exactly one refill.
- wrAddr_o and instBlock_o hold their last written values outside WRITE. Only wrEnable_o qualifies them.
- memReq_o never asserts outside REQ. At most one burst is outstanding.

Decomposition:
- Shared fetch package holds:
  - SIZE_PC, CACHE_WIDTH, MEM_WIDTH.
  - Derived BEATS and BLK_OFF.
  - The refill state encoding (3-bit enum: IDLE=0, REQ=1, FILL=2, WRITE=3, HOLD=4).
- One sub-module, refill_beat_buffer:
  - BEATS x MEM_WIDTH assembly register with write-slice select and a done flag.
  - The FSM and counter stay in the top level.

Test Plan:
- Basic refill:
  - Stimulus: missAddr_i=0x0000_1234, immediate grant, beats 0x11.., 0x22.., 0x33.., 0x44.. on consecutive cycles.
  - Response: memAddr_o=0x0000_1220; wrEnable_o one cycle with wrAddr_o=0x0000_1220; instBlock_o[63:0]=0x11.., instBlock_o[255:192]=0x44..; refillCount_o=1.
- Grant stall:
  - Stimulus: memGnt_i held low for 5 cycles.
  - Response: memReq_o and memAddr_o stay stable for all 5 cycles; exactly one request is accepted.
- Gapped beats:
  - Stimulus: memValid_i pattern 1,0,0,1,1,0,1.
  - Response: the block is assembled in order; wrEnable_o pulses the cycle after the 4th valid beat.
- Redirect mid-fill:
  - Stimulus: missAddr_i changes to 0x0000_4000 during FILL.
  - Response: the first block is written to 0x0000_1220; a second request goes to 0x0000_4000 after HOLD.
- Reset mid-fill:
  - Stimulus: reset=0 after 2 beats, released, followed by 2 stray beats.
  - Response: no wrEnable_o pulse; state IDLE; refillCount_o=0; stray beats ignored.
- Saturation:
  - Stimulus: preload the counter to 0xFFFF_FFFF (via force), then complete one refill.
  - Response: refillCount_o stays at 0xFFFF_FFFF.
